vga_pattern_sequencer: RTL and testbench

//  Sequences the VGA test-pattern generator: picks the active pattern mode and the solid-fill colour.

---
 rtl/vga_pattern_sequencer.sv | 114 +++++++++++
 tb/tb_vga_pattern_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_sequencer.sv
// Pattern-mode sequencer for the VGA test-pattern generator: debounced button or
// dwell-timer advance, applied only on frame boundaries so a frame is never torn.
module vga_pattern_sequencer #(
   parameter int NUM_MODES       = 5,
   parameter int DWELL_FRAMES    = 120,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int FRAME_CNT_W     = 8,
   parameter int DB_CNT_W        = 18
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        frame_start,
   input  logic        btn_next,
   input  logic        auto_en,
   output logic [2:0]  mode,
   output logic [11:0] solid_rgb,
   output logic        mode_update,
   output logic        req_pending
);

   localparam logic [0:0] S_SHOW  = 1'b0;
   localparam logic [0:0] S_ARMED = 1'b1;

   function automatic logic [2:0] next_mode(input logic [2:0] m);
      return (m == 3'(NUM_MODES - 1)) ? 3'd0 : m + 3'd1;
   endfunction

   function automatic logic [11:0] idx_to_rgb(input logic [2:0] i);
      return {{4{i[2]}}, {4{i[1]}}, {4{i[0]}}};
   endfunction

   logic                   btn_meta_p0;
   logic                   btn_sync_p1;
   logic                   btn_db;
   logic                   btn_db_d;
   logic [DB_CNT_W-1:0]    db_cnt;
   logic                   btn_req;
   logic [0:0]             state;
   logic [FRAME_CNT_W-1:0] frame_cnt;
   logic [2:0]             solid_idx;
   logic                   dwell_hit;
   logic                   advance;
   logic [2:0]             mode_nxt;
   logic [2:0]             idx_nxt;

   // Stage p0/p1: two-flop synchroniser for the raw push-button
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_meta_p0 <= 1'b0;
         btn_sync_p1 <= 1'b0;
      end else begin
         btn_meta_p0 <= btn_next;
         btn_sync_p1 <= btn_meta_p0;
      end
   end

   // Debounce: the synced level must hold for DEBOUNCE_CYCLES before it is accepted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_cnt   <= '0;
         btn_db   <= 1'b0;
         btn_db_d <= 1'b0;
      end else begin
         btn_db_d <= btn_db;
         if (btn_sync_p1 == btn_db) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            db_cnt <= '0;
            btn_db <= btn_sync_p1;
         end else begin
            db_cnt <= db_cnt + DB_CNT_W'(1);
         end
      end
   end

   assign btn_req   = btn_db & ~btn_db_d;
   assign dwell_hit = auto_en && (frame_cnt == FRAME_CNT_W'(DWELL_FRAMES - 1));
   // Any combination of sources in one frame_start cycle collapses to a single advance
   assign advance   = frame_start && ((state == S_ARMED) || btn_req || dwell_hit);
   assign mode_nxt  = next_mode(mode);
   assign idx_nxt   = solid_idx + 3'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_SHOW;
         mode        <= 3'd0;
         solid_idx   <= 3'd0;
         solid_rgb   <= 12'h000;
         frame_cnt   <= '0;
         mode_update <= 1'b0;
         req_pending <= 1'b0;
      end else begin
         mode_update <= advance;
         if (advance) begin
            state       <= S_SHOW;
            req_pending <= 1'b0;
            mode        <= mode_nxt;
            frame_cnt   <= '0;
            if (mode_nxt == 3'd1) begin
               solid_idx <= idx_nxt;
               solid_rgb <= idx_to_rgb(idx_nxt);
            end
         end else if (state == S_SHOW) begin
            if (frame_start) begin
               if (auto_en) frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
            end else if (btn_req) begin
               state       <= S_ARMED;
               req_pending <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Bench for vga_pattern_sequencer: a reference model pushes each expected
// {mode, solid_rgb} to a queue, popped whenever the DUT pulses mode_update.
module tb_vga_pattern_sequencer;

   localparam int DW = 3;
   localparam int DB = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        frame_start = 1'b0;
   logic        btn_next = 1'b0;
   logic        auto_en = 1'b0;
   logic [2:0]  mode;
   logic [11:0] solid_rgb;
   logic        mode_update;
   logic        req_pending;

   int n_checks = 0;
   int n_fail   = 0;
   int upd_cnt  = 0;

   logic [14:0] exp_q[$];
   logic [14:0] mon_exp;

   logic [2:0] m_mode = 3'd0;
   logic [2:0] m_idx = 3'd0;
   int         m_fc = 0;
   bit         m_pend = 1'b0;
   bit         m_auto = 1'b0;
   int         m_entries = 0;

   vga_pattern_sequencer #(
      .NUM_MODES(5), .DWELL_FRAMES(DW), .DEBOUNCE_CYCLES(DB),
      .FRAME_CNT_W(8), .DB_CNT_W(18)
   ) dut (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .btn_next(btn_next),
      .auto_en(auto_en), .mode(mode), .solid_rgb(solid_rgb),
      .mode_update(mode_update), .req_pending(req_pending)
   );

   always #20 clk = ~clk;

   initial begin
      #4ms;
      $display("FAIL timeout: simulation still running, expected completion");
      $fatal(1, "timeout");
   end

   always @(negedge clk) begin
      if (rst_n && mode_update) begin
         upd_cnt++;
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected_update: got mode=%0d rgb=%h, expected no update", mode, solid_rgb);
         end else begin
            mon_exp = exp_q.pop_front();
            if ({mode, solid_rgb} !== mon_exp) begin
               n_fail++;
               $display("FAIL sb_mode_rgb: got mode=%0d rgb=%h, expected mode=%0d rgb=%h",
                        mode, solid_rgb, mon_exp[14:12], mon_exp[11:0]);
            end
         end
      end
   end

   function automatic logic [11:0] rgb_of(input logic [2:0] i);
      return {{4{i[2]}}, {4{i[1]}}, {4{i[0]}}};
   endfunction

   task automatic model_advance();
      m_mode = (m_mode == 3'd4) ? 3'd0 : m_mode + 3'd1;
      if (m_mode == 3'd1) begin
         m_idx = m_idx + 3'd1;
         m_entries++;
      end
      exp_q.push_back({m_mode, rgb_of(m_idx)});
      m_fc   = 0;
      m_pend = 1'b0;
   endtask

   task automatic frame();
      bit adv;
      adv = m_pend || (m_auto && m_fc == DW - 1);
      if (adv) model_advance();
      else if (m_auto) m_fc++;
      @(posedge clk); #1 frame_start = 1'b1;
      @(posedge clk); #1 frame_start = 1'b0;
   endtask

   task automatic set_auto(input bit v);
      auto_en = v;
      m_auto  = v;
   endtask

   task automatic press(input int len);
      btn_next = 1'b1;
      repeat (len) @(posedge clk);
      #1 btn_next = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      if (len >= DB) m_pend = 1'b1;
   endtask

   task automatic settle();
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      n_checks += 4;
      if (mode !== 3'd0) begin n_fail++; $display("FAIL rst_mode: got %0d, expected 0", mode); end
      if (solid_rgb !== 12'h000) begin n_fail++; $display("FAIL rst_rgb: got %h, expected 000", solid_rgb); end
      if (mode_update !== 1'b0) begin n_fail++; $display("FAIL rst_update: got %b, expected 0", mode_update); end
      if (req_pending !== 1'b0) begin n_fail++; $display("FAIL rst_pending: got %b, expected 0", req_pending); end
      rst_n = 1'b1;
      settle();
   endtask

   task automatic test_auto();
      int u0;
      u0 = upd_cnt;
      set_auto(1'b1);
      frame();
      frame();
      settle();
      n_checks++;
      if (mode !== 3'd0) begin n_fail++; $display("FAIL auto_early: got mode=%0d, expected 0", mode); end
      frame();
      settle();
      n_checks += 3;
      if (mode !== 3'd1) begin n_fail++; $display("FAIL auto_mode: got %0d, expected 1", mode); end
      if (solid_rgb !== 12'h00F) begin n_fail++; $display("FAIL auto_rgb: got %h, expected 00f", solid_rgb); end
      if (upd_cnt - u0 !== 1) begin n_fail++; $display("FAIL auto_pulses: got %0d, expected 1", upd_cnt - u0); end
   endtask

   task automatic test_button();
      set_auto(1'b0);
      press(2);
      n_checks++;
      if (req_pending !== 1'b0) begin n_fail++; $display("FAIL glitch_pending: got %b, expected 0", req_pending); end
      press(10);
      n_checks += 2;
      if (req_pending !== 1'b1) begin n_fail++; $display("FAIL btn_pending: got %b, expected 1", req_pending); end
      if (mode !== 3'd1) begin n_fail++; $display("FAIL btn_hold_mode: got %0d, expected 1", mode); end
      frame();
      settle();
      n_checks += 2;
      if (mode !== 3'd2) begin n_fail++; $display("FAIL btn_mode: got %0d, expected 2", mode); end
      if (req_pending !== 1'b0) begin n_fail++; $display("FAIL btn_clear: got %b, expected 0", req_pending); end
   endtask

   task automatic test_hold_absorb();
      press(30);
      press(10);
      n_checks++;
      if (req_pending !== 1'b1) begin n_fail++; $display("FAIL hold_pending: got %b, expected 1", req_pending); end
      frame();
      frame();
      settle();
      n_checks++;
      if (mode !== 3'd3) begin n_fail++; $display("FAIL hold_mode: got %0d, expected 3", mode); end
   endtask

   task automatic test_wrap();
      press(10);
      frame();
      press(10);
      frame();
      settle();
      n_checks++;
      if (mode !== 3'd0) begin n_fail++; $display("FAIL wrap_mode: got %0d, expected 0", mode); end
      set_auto(1'b1);
      while (m_entries < 8) frame();
      settle();
      n_checks += 2;
      if (mode !== 3'd1) begin n_fail++; $display("FAIL solid8_mode: got %0d, expected 1", mode); end
      if (solid_rgb !== 12'h000) begin n_fail++; $display("FAIL solid8_rgb: got %h, expected 000", solid_rgb); end
   endtask

   task automatic test_freeze();
      frame();
      set_auto(1'b0);
      repeat (3) frame();
      settle();
      n_checks++;
      if (mode !== 3'd1) begin n_fail++; $display("FAIL freeze_mode: got %0d, expected 1", mode); end
      set_auto(1'b1);
      frame();
      frame();
      settle();
      n_checks++;
      if (mode !== 3'd2) begin n_fail++; $display("FAIL resume_mode: got %0d, expected 2", mode); end
   endtask

   task automatic test_simultaneous();
      frame();
      frame();
      btn_next = 1'b1;
      repeat (6) @(posedge clk);
      #1 frame_start = 1'b1;
      model_advance();
      @(posedge clk);
      #1 frame_start = 1'b0;
      repeat (4) @(posedge clk);
      #1 btn_next = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      n_checks += 2;
      if (req_pending !== 1'b0) begin n_fail++; $display("FAIL simul_pending: got %b, expected 0", req_pending); end
      if (mode !== 3'd3) begin n_fail++; $display("FAIL simul_mode: got %0d, expected 3", mode); end
      frame();
      frame();
      settle();
      n_checks++;
      if (mode !== 3'd3) begin n_fail++; $display("FAIL simul_fc_mode: got %0d, expected 3", mode); end
      frame();
      settle();
      n_checks++;
      if (mode !== 3'd4) begin n_fail++; $display("FAIL simul_next: got %0d, expected 4", mode); end
   endtask

   task automatic test_reset_armed();
      int u0;
      set_auto(1'b0);
      press(10);
      n_checks++;
      if (req_pending !== 1'b1) begin n_fail++; $display("FAIL armed_pending: got %b, expected 1", req_pending); end
      #7 rst_n = 1'b0;
      #1;
      n_checks += 4;
      if (mode !== 3'd0) begin n_fail++; $display("FAIL arst_mode: got %0d, expected 0", mode); end
      if (solid_rgb !== 12'h000) begin n_fail++; $display("FAIL arst_rgb: got %h, expected 000", solid_rgb); end
      if (mode_update !== 1'b0) begin n_fail++; $display("FAIL arst_update: got %b, expected 0", mode_update); end
      if (req_pending !== 1'b0) begin n_fail++; $display("FAIL arst_pending: got %b, expected 0", req_pending); end
      exp_q.delete();
      m_mode = 3'd0; m_idx = 3'd0; m_fc = 0; m_pend = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      u0 = upd_cnt;
      frame();
      settle();
      n_checks += 3;
      if (mode !== 3'd0) begin n_fail++; $display("FAIL arst_noadv_mode: got %0d, expected 0", mode); end
      if (req_pending !== 1'b0) begin n_fail++; $display("FAIL arst_noadv_pend: got %b, expected 0", req_pending); end
      if (upd_cnt !== u0) begin n_fail++; $display("FAIL arst_noadv_upd: got %0d pulses, expected 0", upd_cnt - u0); end
   endtask

   initial begin
      test_reset();
      test_auto();
      test_button();
      test_hold_absorb();
      test_wrap();
      test_freeze();
      test_simultaneous();
      test_reset_armed();
      n_checks++;
      if (exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL sb_leftover: got %0d unmatched advances, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
